// File: rtl/lsu_if.sv
// Load/store unit port bundle: execute request, memory bus, writeback response.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic        rsp_err;

    // slave is the LSU itself; master is the pipeline plus memory around it
    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_ready, mem_rvalid, mem_rdata, rsp_ready,
        output req_ready, mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output rsp_valid, rsp_rdata, rsp_rd, rsp_err
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        output mem_ready, mem_rvalid, mem_rdata, rsp_ready,
        input  req_ready, mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  rsp_valid, rsp_rdata, rsp_rd, rsp_err
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one outstanding access, registered bus and writeback outputs,
// alignment/funct3 checking and an optional read-wait timeout.
module lsu #(
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);
    localparam int unsigned CW  = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam int unsigned LIM = (WAIT_TIMEOUT == 0) ? 0 : WAIT_TIMEOUT - 1;
    localparam logic [CW-1:0] CNT_LIM = CW'(LIM);

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } i_function3_e;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } s_function3_e;

    typedef enum logic [1:0] {
        IDLE,
        MEM_REQ,
        MEM_WAIT,
        RESP
    } state_e;

    state_e state, state_d;

    logic        mem_valid_q, mem_valid_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [4:0]  rsp_rd_q, rsp_rd_d;
    logic        rsp_err_q, rsp_err_d;
    logic        store_q, store_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        f3_ok;
    logic        misaligned;
    logic        dec_err;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [31:0] shifted;
    logic [31:0] ld_data;

    assign bus.req_ready = (state == IDLE) && !rst;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_rd    = rsp_rd_q;
    assign bus.rsp_err   = rsp_err_q;

    always_comb begin
        f3_ok      = 1'b0;
        misaligned = 1'b0;
        st_strb    = 4'b0000;
        st_data    = 32'h0;
        if (bus.req_is_store) begin
            unique case (bus.req_funct3)
                SB: begin
                    f3_ok   = 1'b1;
                    st_strb = 4'b0001 << bus.req_addr[1:0];
                    st_data = {4{bus.req_wdata[7:0]}};
                end
                SH: begin
                    f3_ok      = 1'b1;
                    misaligned = bus.req_addr[0];
                    st_strb    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                    st_data    = {2{bus.req_wdata[15:0]}};
                end
                SW: begin
                    f3_ok      = 1'b1;
                    misaligned = |bus.req_addr[1:0];
                    st_strb    = 4'b1111;
                    st_data    = bus.req_wdata;
                end
                default: ;
            endcase
        end else begin
            unique case (bus.req_funct3)
                LB, LBU: f3_ok = 1'b1;
                LH, LHU: begin
                    f3_ok      = 1'b1;
                    misaligned = bus.req_addr[0];
                end
                LW: begin
                    f3_ok      = 1'b1;
                    misaligned = |bus.req_addr[1:0];
                end
                default: ;
            endcase
        end
        dec_err = !f3_ok || misaligned;
    end

    // Bring the addressed byte/half down to bit 0, then extend
    always_comb begin
        shifted = bus.mem_rdata >> {off_q, 3'b000};
        unique case (f3_q)
            LB:      ld_data = {{24{shifted[7]}}, shifted[7:0]};
            LH:      ld_data = {{16{shifted[15]}}, shifted[15:0]};
            LBU:     ld_data = {24'h0, shifted[7:0]};
            LHU:     ld_data = {16'h0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

    always_comb begin
        state_d     = state;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_rd_d    = rsp_rd_q;
        rsp_err_d   = rsp_err_q;
        store_d     = store_q;
        f3_d        = f3_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    rsp_rd_d = bus.req_rd;
                    store_d  = bus.req_is_store;
                    f3_d     = bus.req_funct3;
                    off_d    = bus.req_addr[1:0];
                    if (dec_err) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0;
                    end else begin
                        state_d     = MEM_REQ;
                        mem_valid_d = 1'b1;
                        mem_we_d    = bus.req_is_store;
                        mem_addr_d  = {bus.req_addr[31:2], 2'b00};
                        mem_wstrb_d = bus.req_is_store ? st_strb : 4'b0000;
                        mem_wdata_d = bus.req_is_store ? st_data : 32'h0;
                    end
                end
            end
            MEM_REQ: begin
                if (bus.mem_ready) begin
                    mem_valid_d = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_wstrb_d = 4'b0000;
                    if (store_q) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = 32'h0;
                    end else begin
                        state_d = MEM_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            MEM_WAIT: begin
                if (bus.mem_rvalid) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = ld_data;
                end else if (WAIT_TIMEOUT != 0 && cnt_q == CNT_LIM) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_rd_q    <= 5'd0;
            rsp_err_q   <= 1'b0;
            store_q     <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            cnt_q       <= '0;
        end else begin
            state       <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_err_q   <= rsp_err_d;
            store_q     <= store_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: a driver pushes expected bus/writeback traffic,
// a monitor pops and compares on every handshake and checks hold stability.
module tb_lsu;
    localparam int unsigned WT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_if bus();

    lsu #(.WAIT_TIMEOUT(WT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } mem_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        err;
    } rsp_exp_t;

    mem_exp_t mem_q[$];
    rsp_exp_t rsp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit rnd_rdy  = 1'b0;
    int rsp_stall = 0;

    logic [31:0] last_rdata, last_addr, last_wdata;
    logic [4:0]  last_rd;
    logic        last_err, last_we;
    logic [3:0]  last_strb;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-level arithmetic from the access rules
    function automatic bit model_err(bit st, bit [2:0] f3, bit [31:0] a);
        int nb;
        if (st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5)) return 1'b1;
        nb = 1 << f3[1:0];
        return (int'(a % 4) % nb) != 0;
    endfunction

    function automatic mem_exp_t model_mem(bit st, bit [2:0] f3, bit [31:0] a, bit [31:0] wd);
        mem_exp_t m;
        int nb;
        int off;
        nb = 1 << f3[1:0];
        off = int'(a % 4);
        m.we = st;
        m.addr = a - (a % 4);
        m.strb = 4'b0000;
        m.data = 32'h0;
        if (st) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= off && i < off + nb) m.strb[i] = 1'b1;
                m.data[8*i +: 8] = wd[8*(i % nb) +: 8];
            end
        end
        return m;
    endfunction

    function automatic logic [31:0] model_load(bit [2:0] f3, bit [31:0] a, bit [31:0] rdata);
        longint v;
        longint mask;
        int nb;
        nb = 1 << f3[1:0];
        v = 0;
        v[31:0] = rdata;
        v = v >> (8 * int'(a % 4));
        mask = (longint'(1) << (8 * nb)) - 1;
        v = v & mask;
        if (!f3[2] && nb < 4 && v > mask / 2) v = v - (mask + 1);
        return v[31:0];
    endfunction

    // writeback back-pressure: forced stalls first, then random or always-ready
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid && rsp_stall > 0) begin
                bus.rsp_ready = 1'b0;
                rsp_stall--;
            end else begin
                bus.rsp_ready = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    // monitor
    logic        pm_v, pm_r, pm_we, pr_v, pr_r, pr_err, p_rst;
    logic [31:0] pm_addr, pm_data, pr_data;
    logic [3:0]  pm_strb;
    logic [4:0]  pr_rd;

    initial begin
        mem_exp_t m;
        rsp_exp_t r;
        p_rst = 1'b1;
        pm_v = 1'b0; pm_r = 1'b0; pr_v = 1'b0; pr_r = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && !p_rst) begin
                if (pm_v && !pm_r) begin
                    check("mem_hold_valid", 32'(bus.mem_valid), 1);
                    check("mem_hold_we", 32'(bus.mem_we), 32'(pm_we));
                    check("mem_hold_addr", bus.mem_addr, pm_addr);
                    check("mem_hold_strb", 32'(bus.mem_wstrb), 32'(pm_strb));
                    check("mem_hold_wdata", bus.mem_wdata, pm_data);
                end
                if (pr_v && !pr_r) begin
                    check("rsp_hold_valid", 32'(bus.rsp_valid), 1);
                    check("rsp_hold_rdata", bus.rsp_rdata, pr_data);
                    check("rsp_hold_rd", 32'(bus.rsp_rd), 32'(pr_rd));
                    check("rsp_hold_err", 32'(bus.rsp_err), 32'(pr_err));
                end
            end
            if (bus.rsp_valid) check("req_ready_in_resp", 32'(bus.req_ready), 0);
            if (!rst && bus.mem_valid) begin
                n_checks++;
                if (mem_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL mem_unexpected: mem_valid=1 addr %h with nothing expected", bus.mem_addr);
                end else if (bus.mem_ready) begin
                    m = mem_q.pop_front();
                    check("mem_we", 32'(bus.mem_we), 32'(m.we));
                    check("mem_addr", bus.mem_addr, m.addr);
                    check("mem_wstrb", 32'(bus.mem_wstrb), 32'(m.strb));
                    check("mem_wdata", bus.mem_wdata, m.data);
                    last_we = bus.mem_we;
                    last_addr = bus.mem_addr;
                    last_strb = bus.mem_wstrb;
                    last_wdata = bus.mem_wdata;
                end
            end
            if (!rst && bus.rsp_valid && bus.rsp_ready) begin
                n_checks++;
                if (rsp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected: rsp_valid=1 rd %0d with nothing expected", bus.rsp_rd);
                end else begin
                    r = rsp_q.pop_front();
                    check("rsp_rdata", bus.rsp_rdata, r.rdata);
                    check("rsp_rd", 32'(bus.rsp_rd), 32'(r.rd));
                    check("rsp_err", 32'(bus.rsp_err), 32'(r.err));
                    last_rdata = bus.rsp_rdata;
                    last_rd = bus.rsp_rd;
                    last_err = bus.rsp_err;
                end
            end
            pm_v = bus.mem_valid; pm_r = bus.mem_ready; pm_we = bus.mem_we;
            pm_addr = bus.mem_addr; pm_strb = bus.mem_wstrb; pm_data = bus.mem_wdata;
            pr_v = bus.rsp_valid; pr_r = bus.rsp_ready; pr_data = bus.rsp_rdata;
            pr_rd = bus.rsp_rd; pr_err = bus.rsp_err;
            p_rst = rst;
        end
    end

    task automatic accept(output bit ok);
        int g = 0;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        ok = bus.req_ready;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles", g);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr = $urandom;
        bus.req_wdata = $urandom;
        bus.req_rd = 5'($urandom);
    endtask

    task automatic txn(bit st, bit [2:0] f3, bit [31:0] a, bit [31:0] wd, bit [4:0] rd,
                       bit [31:0] rdata, int stall, int dly);
        bit e;
        bit ok;
        rsp_exp_t r;
        e = model_err(st, f3, a);
        r.rd = rd;
        r.err = e;
        r.rdata = 32'h0;
        if (!e) begin
            mem_q.push_back(model_mem(st, f3, a, wd));
            if (!st) begin
                if (dly < int'(WT)) r.rdata = model_load(f3, a, rdata);
                else r.err = 1'b1;
            end
        end
        rsp_q.push_back(r);
        bus.req_is_store = st;
        bus.req_funct3 = f3;
        bus.req_addr = a;
        bus.req_wdata = wd;
        bus.req_rd = rd;
        accept(ok);
        if (!ok) return;
        if (e) begin
            check("err_rsp_at_t1", 32'(bus.rsp_valid), 1);
            check("err_no_mem", 32'(bus.mem_valid), 0);
            return;
        end
        check("mem_valid_at_t1", 32'(bus.mem_valid), 1);
        repeat (stall) @(negedge clk);
        bus.mem_ready = 1'b1;
        bus.mem_rvalid = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.mem_rvalid = 1'b0;
        if (st) begin
            check("st_rsp_after_mem", 32'(bus.rsp_valid), 1);
            return;
        end
        for (int i = 0; i < dly && i < int'(WT); i++) @(negedge clk);
        if (dly >= int'(WT)) begin
            check("tmo_rsp_valid", 32'(bus.rsp_valid), 1);
            check("tmo_rsp_err", 32'(bus.rsp_err), 1);
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata = $urandom;
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            return;
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = rdata;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = $urandom;
        check("ld_rsp_after_rvalid", 32'(bus.rsp_valid), 1);
    endtask

    task automatic drain();
        int g = 0;
        while ((rsp_q.size() != 0 || mem_q.size() != 0) && g < 200) begin
            @(negedge clk);
            g++;
        end
        n_checks++;
        if (rsp_q.size() != 0 || mem_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d rsp and %0d mem still expected", rsp_q.size(), mem_q.size());
        end
    endtask

    task automatic reset_midflight();
        bit ok;
        mem_q.push_back(model_mem(1'b0, 3'b010, 32'h4000, 32'h0));
        bus.req_is_store = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h4000;
        bus.req_rd = 5'd21;
        accept(ok);
        if (!ok) return;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mem_valid", 32'(bus.mem_valid), 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_rsp_rd", 32'(bus.rsp_rd), 0);
        check("rst_req_ready", 32'(bus.req_ready), 0);
        rst = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        @(negedge clk);
        check("post_rst_req_ready", 32'(bus.req_ready), 1);
        check("post_rst_rsp_valid", 32'(bus.rsp_valid), 0);
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        check("post_rst_rsp_valid2", 32'(bus.rsp_valid), 0);
        check("post_rst_rsp_rdata", bus.rsp_rdata, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit st;
        bit [2:0] f3;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0;
        bus.req_rd = 5'd0;
        bus.mem_ready = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_mem_valid", 32'(bus.mem_valid), 0);
        check("reset_mem_wstrb", 32'(bus.mem_wstrb), 0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 0);
        check("reset_rsp_err", 32'(bus.rsp_err), 0);
        check("reset_req_ready", 32'(bus.req_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 32'(bus.req_ready), 1);

        txn(1'b0, 3'b000, 32'h1003, 32'h0, 5'd7, 32'h80FF_FF00, 0, 0);
        drain();
        check("lb_result", last_rdata, 32'hFFFF_FF80);
        check("lb_err", 32'(last_err), 0);
        txn(1'b0, 3'b100, 32'h1003, 32'h0, 5'd8, 32'h80FF_FF00, 1, 2);
        drain();
        check("lbu_result", last_rdata, 32'h0000_0080);

        txn(1'b1, 3'b001, 32'h2002, 32'h1234_ABCD, 5'd9, 32'h0, 0, 0);
        drain();
        check("sh_wstrb", 32'(last_strb), 32'hC);
        check("sh_wdata", last_wdata, 32'hABCD_ABCD);
        check("sh_addr", last_addr, 32'h2000);
        check("sh_we", 32'(last_we), 1);
        check("sh_rdata", last_rdata, 0);

        txn(1'b0, 3'b010, 32'h3001, 32'h0, 5'd17, 32'h0, 0, 0);
        drain();
        check("lw_mis_err", 32'(last_err), 1);
        check("lw_mis_rd", 32'(last_rd), 17);

        rsp_stall = 2;
        txn(1'b0, 3'b001, 32'h5006, 32'h0, 5'd3, 32'hCAFE_F00D, 3, 1);
        drain();
        check("lh_stall_result", last_rdata, 32'hFFFF_CAFE);

        txn(1'b0, 3'b101, 32'h6002, 32'h0, 5'd4, 32'hFFFF_FFFF, 0, 10);
        drain();
        check("tmo_err", 32'(last_err), 1);
        check("tmo_rdata", last_rdata, 0);
        txn(1'b0, 3'b010, 32'h6004, 32'h0, 5'd5, 32'h0BAD_BEEF, 0, int'(WT) - 1);
        drain();
        check("last_cycle_rvalid", last_rdata, 32'h0BAD_BEEF);

        reset_midflight();
        drain();

        rnd_rdy = 1'b1;
        repeat (300) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f3[1:0] = 2'($urandom_range(0, 2));
            txn(st, f3, $urandom, $urandom, 5'($urandom), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 5));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
